// File: rtl/perceptron_pkg.sv
// Shared types and saturating arithmetic for the perceptron training datapath.
// Element width defaults to 8 bits unless DATA_WIDTH is defined before this file.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package perceptron_pkg;

  localparam int DW = `DATA_WIDTH;
  localparam int PW = 2*DW + 1;  // err (DW+1 bits) times x (DW bits)
  localparam int SW = 2*DW + 2;  // accumulator plus product, never overflows

  localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, UPD_W, UPD_B, DONE} upd_state_t;

  function automatic logic signed [DW-1:0] sat_add(input logic signed [DW-1:0] a,
                                                   input logic signed [PW-1:0] d);
    logic signed [SW-1:0] sum;
    sum = $signed({{(SW-DW){a[DW-1]}}, a}) + $signed({d[PW-1], d});
    // In range exactly when every bit above the result sign matches it
    if ((&sum[SW-1:DW-1]) || !(|sum[SW-1:DW-1]))
      return sum[DW-1:0];
    else if (sum[SW-1])
      return SAT_MIN;
    else
      return SAT_MAX;
  endfunction

endpackage

// File: rtl/perceptron_update_sat_mac_shift.sv
// Combinational res = sat(acc + ((err * x) >>> LR_SHIFT)); shared by weight and bias updates.
module sat_mac_shift
  import perceptron_pkg::*;
#(
  parameter int LR_SHIFT = 2
) (
  input  logic [DW:0]   err_i,
  input  logic [DW-1:0] x_i,
  input  logic [DW-1:0] acc_i,
  output logic [DW-1:0] res_o
);

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] delta;

  assign prod  = $signed({{(PW-DW-1){err_i[DW]}}, err_i}) *
                 $signed({{(PW-DW){x_i[DW-1]}}, x_i});
  assign delta = prod >>> LR_SHIFT;
  assign res_o = sat_add($signed(acc_i), delta);

endmodule

// File: rtl/perceptron_update.sv
// Perceptron learning-rule engine: owns w/b, applies one weight per cycle, then the bias.
module perceptron_update
  import perceptron_pkg::*;
#(
  parameter int N          = 4,
  parameter int DATA_WIDTH = DW,
  parameter int LR_SHIFT   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0]   y,
  input  logic [DATA_WIDTH-1:0]   target,
  output logic [N*DATA_WIDTH-1:0] w,
  output logic [DATA_WIDTH-1:0]   b,
  output logic                    busy,
  output logic                    done
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  upd_state_t    state_q, state_d;
  logic [IW-1:0] idx_q;
  logic [DW:0]   err_q;
  logic [DW:0]   err_in;
  logic [DW-1:0] x_q [N];
  logic [DW-1:0] w_q [N];
  logic [DW-1:0] b_q;
  logic [DW-1:0] mac_x, mac_acc, mac_res;
  logic          accept;
  logic          last_idx;

  assign in_ready = (state_q == IDLE);
  assign busy     = ~in_ready;
  assign done     = (state_q == DONE);
  assign accept   = in_valid && in_ready;
  assign last_idx = (idx_q == IW'(N-1));
  assign err_in   = {target[DW-1], target} - {y[DW-1], y};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (err_in == '0) ? DONE : UPD_W;
      UPD_W:   if (last_idx) state_d = UPD_B;
      UPD_B:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // The bias pass reuses the weight MAC with x forced to 1
  assign mac_x   = (state_q == UPD_B) ? {{(DW-1){1'b0}}, 1'b1} : x_q[idx_q];
  assign mac_acc = (state_q == UPD_B) ? b_q : w_q[idx_q];

  sat_mac_shift #(.LR_SHIFT(LR_SHIFT)) u_mac (
    .err_i (err_q),
    .x_i   (mac_x),
    .acc_i (mac_acc),
    .res_o (mac_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      err_q <= '0;
      b_q   <= '0;
      for (int i = 0; i < N; i++) begin
        x_q[i] <= '0;
        w_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            err_q <= err_in;
            idx_q <= '0;
            for (int i = 0; i < N; i++) x_q[i] <= x[i*DW +: DW];
          end
        end
        UPD_W: begin
          w_q[idx_q] <= mac_res;
          idx_q      <= last_idx ? '0 : idx_q + 1'b1;
        end
        UPD_B:   b_q <= mac_res;
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_wout
    assign w[gi*DW +: DW] = w_q[gi];
  end

  assign b = b_q;

endmodule
